tr_sequencer: RTL and testbench
===============================

Name: tr_sequencer

Overview:
- Timed TX/RX sequencer placed downstream of the I/O block's combined PTT (cmd_ptt | cwkey | ext_ptt, gated by txinhibit).
- Replaces the direct combinational drive of PA/T-R/power outputs:
  - powers the envelope/bias rails first,
  - then switches the T/R relays,
  - then enables the TX DAC path.
- Reverses the order on unkey, with a host-programmable PTT hang time for CW.
- All outputs are registered and glitch-free.

Parameters:
T_PWR, 24'd384000, clocks from rail enable to relay switch (5 ms at 76.8 MHz)
T_TR, 24'd76800, clocks of relay settle, applied on key and unkey (1 ms)
CLKS_PER_MS, 17'd76800, prescaler terminal count for the 1 ms hang tick
HANG_ADDR, 6'h17, command address carrying the hang time

Ports:
clk  in  1  system clock, 76.8 MHz
rst  in  1  reset, asynchronous, active-low
ptt_in  in  1  combined PTT request from I/O block
ext_txinhibit  in  1  debounced external TX inhibit, 1 = inhibit
pa_enable  in  1  PA enable, from cmd 0x09 bit 19
tr_disable  in  1  T/R disable, from cmd 0x09 bit 18
vna  in  1  VNA mode, from cmd 0x09 bit 23
cmd_addr  in  6  host command address
cmd_data  in  32  host command data
cmd_rqst  in  1  one-cycle command strobe
tx_en  out  1  TX DAC path enable
pwr_envop  out  1  envelope op-amp rail enable
pwr_envbias  out  1  PA bias enable
pa_exttr  out  1  external T/R key
pa_inttr  out  1  internal T/R relay
seq_busy  out  1  1 whenever the state is not IDLE
seq_state  out  3  current state encoding, for status/debug

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, all outputs 0, counters 0.
  - hang_ms = 8'd0.
- Hang register: on cmd_rqst & cmd_addr==HANG_ADDR, hang_ms <= cmd_data[7:0] (units of ms). A write takes effect at the next HANG entry.
- Single 24-bit down-counter dly:
  - On a state entry, the counter is loaded with N, and the state lasts max(N,1) cycles.
  - "done" means dly==0 or dly==1 at the final cycle.
- Outputs are registered from the next state, so they change on the same edge as the state.
- States and transitions:
  - IDLE (0): all outputs 0, except pwr_envop = vna & ~ext_txinhibit.
    - ptt_in & ~ext_txinhibit -> PWR_ON, load T_PWR.
  - PWR_ON (1): pwr_envop=1, pwr_envbias=pa_enable.
    - done -> TR_ON, load T_TR.
    - ~ptt_in -> IDLE (relays never touched).
  - TR_ON (2): as PWR_ON, plus pa_exttr=1 and pa_inttr = pa_enable | ~tr_disable.
    - done -> TX.
    - ~ptt_in -> TR_OFF, load T_TR.
  - TX (3): as TR_ON, plus tx_en=1.
    - ~ptt_in -> HANG; ms prescaler cleared; hang counter loaded with hang_ms.
  - HANG (4): as TR_ON, with tx_en=0.
    - ptt_in -> TX; tx_en rises on the next edge, with no settle delay.
    - Hang counter reaches 0 on a ms tick -> TR_OFF, load T_TR.
    - hang_ms==0 -> TR_OFF after exactly 1 cycle.
  - TR_OFF (5): relays 0, pwr_envop=1, pwr_envbias=pa_enable.
    - done -> IDLE.
    - ptt_in is ignored until IDLE is reached; re-keying then restarts at PWR_ON.
- ext_txinhibit=1 in any state -> IDLE next edge; all outputs 0 (VNA rail also blocked). Inhibit has priority over all other transitions.
- pa_enable, tr_disable or vna changing mid-sequence: combinational terms are re-evaluated every cycle; no state change.
- ms prescaler:
  - counts 0..CLKS_PER_MS-1 only while in HANG;
  - wraps and emits a 1-cycle tick at the terminal count;
  - is held at 0 in all other states.
- No combinational path from any input to any output.

Decomposition:
- Package tr_seq_pkg holds:
  - the state enum (3-bit, encodings 0-5 as listed above),
  - the HANG_ADDR constant,
  - DLY_W=24 and HANG_W=8.
- One sub-module, ms_tick: prescaler with clear input and tick output, parameterised by CLKS_PER_MS.

Test Plan:
- Bench parameters: T_PWR=4, T_TR=2, CLKS_PER_MS=10; pa_enable=1, tr_disable=0.
- Basic key/unkey:
  - Raise ptt_in at cycle 0 -> pwr_envop/pwr_envbias=1 at edge 1; pa_exttr/pa_inttr=1 at edge 5; tx_en=1 at edge 7.
  - Drop ptt with hang_ms=0 -> tx_en=0 at the next edge; relays drop 1 cycle later; rails drop T_TR cycles after that; seq_busy=0.
- Hang and re-key: write cmd_addr=0x17, cmd_data=3; key for 20 cycles, then drop ptt -> relays held 30 cycles, then TR_OFF. Re-key at hang cycle 15 -> tx_en=1 on the next edge, relays never drop.
- Aborted key: ptt pulse of 2 cycles -> PWR_ON then IDLE; pa_exttr and tx_en stay 0 throughout.
- Inhibit: assert ext_txinhibit during TX -> all outputs 0 and seq_state=0 on the next edge. Keep ptt high -> no re-key until inhibit drops, then the full sequence restarts.
- Mode variants:
  - pa_enable=0, tr_disable=1 in TX -> pa_inttr=0, pwr_envbias=0, pa_exttr=1.
  - IDLE with vna=1 -> pwr_envop=1, other outputs 0.
  - Assert rst=0 mid-TX -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tr_seq_pkg.sv
// Shared types and constants for the TX/RX sequencer: state encoding, output bundle, hang address.
// Pure declarations plus the state-to-output decode, so every file agrees on what each state drives.
package tr_seq_pkg;

  localparam int DLY_W  = 24;
  localparam int HANG_W = 8;

  localparam logic [5:0] HANG_ADDR = 6'h17;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PWR_ON = 3'd1,
    TR_ON  = 3'd2,
    TX     = 3'd3,
    HANG   = 3'd4,
    TR_OFF = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic tx_en;
    logic pwr_envop;
    logic pwr_envbias;
    logic pa_exttr;
    logic pa_inttr;
  } seq_out_t;

  // Mode inputs are folded in here every cycle, so flipping them mid-sequence never moves the state.
  function automatic seq_out_t decode_outputs(input seq_state_t st, input logic pa_enable,
                                              input logic tr_disable, input logic vna,
                                              input logic inhibit);
    seq_out_t o;
    o = '0;
    case (st)
      IDLE: o.pwr_envop = vna & ~inhibit;
      PWR_ON, TR_OFF: begin
        o.pwr_envop   = 1'b1;
        o.pwr_envbias = pa_enable;
      end
      TR_ON, TX, HANG: begin
        o.pwr_envop   = 1'b1;
        o.pwr_envbias = pa_enable;
        o.pa_exttr    = 1'b1;
        o.pa_inttr    = pa_enable | ~tr_disable;
        o.tx_en       = (st == TX);
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/tr_sequencer_ms_tick.sv
// Millisecond prescaler: counts 0..CLKS_PER_MS-1 while clear is low, one-cycle tick on the terminal count.
// Held at zero while clear is high, so each hang period starts from a full millisecond.
module ms_tick #(
  parameter logic [16:0] CLKS_PER_MS = 17'd76800
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  logic [16:0] cnt;
  logic        wrap;

  assign wrap = (cnt == CLKS_PER_MS - 17'd1);
  assign tick = wrap & ~clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 17'd0;
    end else if (clear || wrap) begin
      cnt <= 17'd0;
    end else begin
      cnt <= cnt + 17'd1;
    end
  end

endmodule

// File: rtl/tr_sequencer.sv
// Timed PTT sequencer: rails, then T/R relays, then TX DAC on key; reverse order with CW hang on unkey.
// Every output is a flop loaded from the next state, so outputs move on the same edge as the state.
module tr_sequencer
  import tr_seq_pkg::*;
#(
  parameter logic [DLY_W-1:0] T_PWR       = 24'd384000,
  parameter logic [DLY_W-1:0] T_TR        = 24'd76800,
  parameter logic [16:0]      CLKS_PER_MS = 17'd76800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ptt_in,
  input  logic        ext_txinhibit,
  input  logic        pa_enable,
  input  logic        tr_disable,
  input  logic        vna,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        cmd_rqst,
  output logic        tx_en,
  output logic        pwr_envop,
  output logic        pwr_envbias,
  output logic        pa_exttr,
  output logic        pa_inttr,
  output logic        seq_busy,
  output logic [2:0]  seq_state
);

  localparam logic [DLY_W-1:0]  DLY_ONE  = 1;
  localparam logic [HANG_W-1:0] HANG_ONE = 1;

  seq_state_t        state, nxt_state;
  logic [DLY_W-1:0]  dly, nxt_dly;
  logic [HANG_W-1:0] hang_ms, hang_cnt, nxt_hang;
  logic              done, tick;
  seq_out_t          outs;
  logic              cmd_data_unused;

  assign cmd_data_unused = ^cmd_data[31:HANG_W];

  ms_tick #(.CLKS_PER_MS(CLKS_PER_MS)) u_ms_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state != HANG),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hang_ms <= '0;
    end else if (cmd_rqst && cmd_addr == HANG_ADDR) begin
      hang_ms <= cmd_data[HANG_W-1:0];
    end
  end

  // A load of 0 or 1 both give a one-cycle state, hence done on either value.
  assign done = (dly <= DLY_ONE);

  always_comb begin
    nxt_state = state;
    nxt_dly   = (dly != '0) ? dly - DLY_ONE : '0;
    nxt_hang  = hang_cnt;
    if (ext_txinhibit) begin
      nxt_state = IDLE;
      nxt_dly   = '0;
    end else begin
      case (state)
        IDLE: if (ptt_in) begin
          nxt_state = PWR_ON;
          nxt_dly   = T_PWR;
        end
        // Dropping PTT wins over a settle expiring in the same cycle, so the relays never move unkeyed.
        PWR_ON: if (!ptt_in) begin
          nxt_state = IDLE;
          nxt_dly   = '0;
        end else if (done) begin
          nxt_state = TR_ON;
          nxt_dly   = T_TR;
        end
        TR_ON: if (!ptt_in) begin
          nxt_state = TR_OFF;
          nxt_dly   = T_TR;
        end else if (done) begin
          nxt_state = TX;
        end
        TX: if (!ptt_in) begin
          nxt_state = HANG;
          nxt_hang  = hang_ms;
        end
        HANG: if (ptt_in) begin
          nxt_state = TX;
        end else if (hang_cnt == '0 || (tick && hang_cnt == HANG_ONE)) begin
          nxt_state = TR_OFF;
          nxt_dly   = T_TR;
        end else if (tick) begin
          nxt_hang = hang_cnt - HANG_ONE;
        end
        TR_OFF: if (done) begin
          nxt_state = IDLE;
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dly      <= '0;
      hang_cnt <= '0;
      outs     <= '0;
      seq_busy <= 1'b0;
    end else begin
      state    <= nxt_state;
      dly      <= nxt_dly;
      hang_cnt <= nxt_hang;
      outs     <= decode_outputs(nxt_state, pa_enable, tr_disable, vna, ext_txinhibit);
      seq_busy <= (nxt_state != IDLE);
    end
  end

  assign seq_state   = state;
  assign tx_en       = outs.tx_en;
  assign pwr_envop   = outs.pwr_envop;
  assign pwr_envbias = outs.pwr_envbias;
  assign pa_exttr    = outs.pa_exttr;
  assign pa_inttr    = outs.pa_inttr;

endmodule

// File: tb/tb_tr_sequencer.sv
// Bench for tr_sequencer: directed key/hang/abort/inhibit/mode/reset scenarios, then random PTT traffic,
// all compared each cycle against an elapsed-time reference model.
module tb_tr_sequencer;

  localparam logic [23:0] TP  = 24'd4;
  localparam logic [23:0] TT  = 24'd2;
  localparam logic [16:0] CPM = 17'd10;

  logic        clk = 1'b0;
  logic        rst;
  logic        ptt_in, ext_txinhibit, pa_enable, tr_disable, vna, cmd_rqst;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        tx_en, pwr_envop, pwr_envbias, pa_exttr, pa_inttr, seq_busy;
  logic [2:0]  seq_state;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: phase number, cycles spent in it, hang register and hang value latched on unkey.
  int         ph, age, hang_reg, hang_lat;
  logic [8:0] exp_vec;
  logic       seen;

  tr_sequencer #(.T_PWR(TP), .T_TR(TT), .CLKS_PER_MS(CPM)) dut (
    .clk           (clk),
    .rst           (rst),
    .ptt_in        (ptt_in),
    .ext_txinhibit (ext_txinhibit),
    .pa_enable     (pa_enable),
    .tr_disable    (tr_disable),
    .vna           (vna),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .cmd_rqst      (cmd_rqst),
    .tx_en         (tx_en),
    .pwr_envop     (pwr_envop),
    .pwr_envbias   (pwr_envbias),
    .pa_exttr      (pa_exttr),
    .pa_inttr      (pa_inttr),
    .seq_busy      (seq_busy),
    .seq_state     (seq_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] dut_vec();
    return {seq_busy, seq_state, tx_en, pwr_envop, pwr_envbias, pa_exttr, pa_inttr};
  endfunction

  function automatic int dur(input logic [23:0] n);
    return (n == 24'd0) ? 1 : int'(n);
  endfunction

  function automatic logic [8:0] model_vec(input int p, input logic pa, input logic td,
                                           input logic vn, input logic ih);
    logic [2:0] s;
    logic env, bias, ext, intr, tx;
    s    = p[2:0];
    env  = (p == 0) ? (vn & ~ih) : 1'b1;
    bias = (p != 0) & pa;
    ext  = (p == 2) || (p == 3) || (p == 4);
    intr = ext & (pa | ~td);
    tx   = (p == 3);
    return {p != 0, s, tx, env, bias, ext, intr};
  endfunction

  task automatic model_step();
    int nxt;
    int hdur;
    if (!rst) begin
      ph = 0; age = 0; hang_reg = 0; hang_lat = 0;
    end else begin
      nxt  = ph;
      hdur = (hang_lat == 0) ? 1 : hang_lat * int'(CPM);
      if (ext_txinhibit) nxt = 0;
      else begin
        case (ph)
          0: if (ptt_in) nxt = 1;
          1: if (!ptt_in) nxt = 0; else if (age + 1 >= dur(TP)) nxt = 2;
          2: if (!ptt_in) nxt = 5; else if (age + 1 >= dur(TT)) nxt = 3;
          3: if (!ptt_in) begin nxt = 4; hang_lat = hang_reg; end
          4: if (ptt_in) nxt = 3; else if (age + 1 >= hdur) nxt = 5;
          5: if (age + 1 >= dur(TT)) nxt = 0;
          default: nxt = 0;
        endcase
      end
      age = (nxt != ph) ? 0 : age + 1;
      ph  = nxt;
      if (cmd_rqst && cmd_addr == 6'h17) hang_reg = int'(cmd_data[7:0]);
    end
    exp_vec = model_vec(ph, pa_enable, tr_disable, vna, ext_txinhibit);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check($sformatf("cycle_ph%0d_age%0d", ph, age), 32'(dut_vec()), 32'(exp_vec));
  endtask

  initial begin
    rst = 1'b1; ptt_in = 1'b0; ext_txinhibit = 1'b0; pa_enable = 1'b1; tr_disable = 1'b0;
    vna = 1'b0; cmd_rqst = 1'b0; cmd_addr = 6'h0; cmd_data = 32'h0;
    ph = 0; age = 0; hang_reg = 0; hang_lat = 0; seen = 1'b0;
    #2 rst = 1'b0;
    #1 check("reset_no_clock", 32'(dut_vec()), 32'h0);
    step(); step();
    rst = 1'b1;

    // Basic key with hang 0.
    ptt_in = 1'b1;
    step(); check("key_rails_e1", {pwr_envop, pwr_envbias, pa_exttr}, 3'b110);
    repeat (3) step();
    step(); check("key_relays_e5", {pa_exttr, pa_inttr, tx_en}, 3'b110);
    step();
    step(); check("key_tx_e7", tx_en, 1);
    repeat (3) step();
    ptt_in = 1'b0;
    step(); check("unkey_tx_off", {tx_en, pa_exttr}, 2'b01);
    step(); check("unkey_relays_off", {pa_exttr, pwr_envop}, 2'b01);
    step(); check("unkey_rails_hold", pwr_envop, 1);
    step(); check("unkey_idle", {seq_busy, pwr_envop}, 2'b00);

    // Hang of 3 ms, then re-key inside the hang.
    cmd_addr = 6'h17; cmd_data = 32'd3; cmd_rqst = 1'b1;
    step(); cmd_rqst = 1'b0;
    ptt_in = 1'b1; repeat (20) step(); ptt_in = 1'b0;
    repeat (30) step(); check("hang_hold30", {seq_state, pa_exttr}, {3'd4, 1'b1});
    step(); check("hang_expire", {seq_state, pa_exttr}, {3'd5, 1'b0});
    repeat (3) step();
    ptt_in = 1'b1; repeat (20) step(); ptt_in = 1'b0;
    repeat (15) step(); check("rekey_in_hang", seq_state, 3'd4);
    ptt_in = 1'b1;
    step(); check("rekey_tx", {seq_state, tx_en, pa_exttr}, {3'd3, 2'b11});
    repeat (3) step();
    ptt_in = 1'b0; repeat (40) step();
    check("rekey_final_idle", seq_busy, 0);

    // Aborted key: two-cycle pulse never reaches the relays.
    ptt_in = 1'b1; seen = 1'b0;
    repeat (2) begin step(); seen = seen | pa_exttr | tx_en; end
    ptt_in = 1'b0;
    step(); check("abort_idle", seq_state, 3'd0);
    repeat (4) begin step(); seen = seen | pa_exttr | tx_en; end
    check("abort_no_relay", seen, 0);

    // Inhibit during TX with PTT held.
    ptt_in = 1'b1; repeat (8) step(); check("inh_pre_tx", seq_state, 3'd3);
    ext_txinhibit = 1'b1; vna = 1'b1;
    step(); check("inh_all_off", 32'(dut_vec()), 32'h0);
    repeat (5) step(); check("inh_hold", {seq_state, pwr_envop}, 4'h0);
    ext_txinhibit = 1'b0; vna = 1'b0;
    step(); check("inh_restart", {seq_state, pwr_envop, pa_exttr}, {3'd1, 2'b10});
    repeat (8) step();

    // Mode variants.
    pa_enable = 1'b0; tr_disable = 1'b1;
    step(); check("mode_pa0_trdis", {seq_state, pa_inttr, pwr_envbias, pa_exttr}, {3'd3, 3'b001});
    pa_enable = 1'b1; tr_disable = 1'b0; ptt_in = 1'b0;
    repeat (36) step();
    vna = 1'b1;
    step(); check("vna_idle", 32'(dut_vec()), 32'h008);
    vna = 1'b0;
    step();

    // Asynchronous reset mid-TX.
    ptt_in = 1'b1; repeat (8) step();
    #2 rst = 1'b0;
    #1 check("arst_async", {tx_en, pwr_envop, pwr_envbias, pa_exttr, pa_inttr, seq_busy, seq_state}, 0);
    step();
    rst = 1'b1; ptt_in = 1'b0;
    step();

    // Random traffic.
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 11) == 0) ptt_in = ~ptt_in;
      ext_txinhibit = ($urandom_range(0, 50) == 0);
      if ($urandom_range(0, 30) == 0) begin
        pa_enable  = 1'($urandom_range(0, 1));
        tr_disable = 1'($urandom_range(0, 1));
        vna        = 1'($urandom_range(0, 1));
      end
      cmd_rqst = ($urandom_range(0, 25) == 0);
      cmd_addr = ($urandom_range(0, 1) == 1) ? 6'h17 : 6'($urandom_range(0, 63));
      cmd_data = {24'($urandom), 8'($urandom_range(0, 3))};
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
